// File: rtl/uart_alu.sv
// UART-attached 32-bit integer ALU.
// An 8N1 receiver feeds a byte FIFO. A packet parser reads that FIFO and
// either accumulates ADD/MUL/DIV over the operands or forwards ECHO payload.
// Results and echoed bytes go through a second FIFO into an 8N1 transmitter.
// The packet layer assumes DATA_WIDTH == 8.

module uart_alu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign data_o  = mem_q[rd_q];

    // Pointer and occupancy update; a push into a full FIFO is dropped.
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end
endmodule

module uart_alu #(
    parameter int PRESCALE   = 410,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic tx_o
);
    localparam int CNT_W = $clog2(8 * PRESCALE);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(8 * PRESCALE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(4 * PRESCALE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_MUL  = 8'h02;
    localparam logic [7:0] OP_DIV  = 8'h03;
    localparam logic [7:0] OP_ECHO = 8'hEC;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {
        P_OPCODE, P_RSVD, P_LEN_LO, P_LEN_HI, P_PAYLOAD, P_EXEC, P_RESPOND
    } parse_state_t;

    // Receiver signals
    logic                  rx_meta_q, rx_sync_q;
    rx_state_t             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic                  rx_valid;

    // FIFO signals
    logic                  rx_pop, rx_empty, rx_full;
    logic [DATA_WIDTH-1:0] rx_head;
    logic                  tx_push, tx_pop, tx_empty, tx_full;
    logic [DATA_WIDTH-1:0] tx_data, tx_head;

    // Parser and datapath signals
    parse_state_t p_state_q, p_state_d;
    logic [7:0]   opcode_q, opcode_d;
    logic [7:0]   len_lo_q, len_lo_d;
    logic [15:0]  remain_q, remain_d;
    logic [31:0]  operand_q, operand_d;
    logic [1:0]   byte_idx_q, byte_idx_d;
    logic         first_q, first_d;
    logic [31:0]  acc_q, acc_d;
    logic [1:0]   resp_idx_q, resp_idx_d;
    logic         div_busy_q, div_busy_d;
    logic [4:0]   div_cnt_q, div_cnt_d;
    logic [31:0]  div_rem_q, div_rem_d;
    logic [31:0]  div_quo_q, div_quo_d;
    logic [31:0]  div_den_q, div_den_d;
    logic         div_neg_q, div_neg_d;
    logic [31:0]  full_word, div_quo_next;
    logic [32:0]  div_shift, div_diff;
    logic [15:0]  pkt_len;
    logic         payload_ok, is_arith;

    // Transmitter signals
    tx_state_t             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_q, tx_d;

    assign tx_o = tx_q;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver: validate start at mid-bit, sample data at bit centres, drop bytes with a low stop bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_valid   = rx_sync_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    uart_alu_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(8)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_valid),
        .data_i  (rx_shift_q),
        .pop_i   (rx_pop),
        .data_o  (rx_head),
        .empty_o (rx_empty),
        .full_o  (rx_full)
    );

    // Parser and accumulator: header decode, operand assembly, iterative signed divide, response.
    always_comb begin
        p_state_d  = p_state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        remain_d   = remain_q;
        operand_d  = operand_q;
        byte_idx_d = byte_idx_q;
        first_d    = first_q;
        acc_d      = acc_q;
        resp_idx_d = resp_idx_q;
        div_busy_d = div_busy_q;
        div_cnt_d  = div_cnt_q;
        div_rem_d  = div_rem_q;
        div_quo_d  = div_quo_q;
        div_den_d  = div_den_q;
        div_neg_d  = div_neg_q;
        rx_pop     = 1'b0;
        tx_push    = 1'b0;
        tx_data    = '0;

        full_word    = {rx_head, operand_q[31:8]};
        pkt_len      = {rx_head, len_lo_q};
        is_arith     = (opcode_q == OP_ADD) || (opcode_q == OP_MUL) || (opcode_q == OP_DIV);
        payload_ok   = !rx_empty && !div_busy_q && !((opcode_q == OP_ECHO) && tx_full);
        div_shift    = {div_rem_q, div_quo_q[31]};
        div_diff     = div_shift - {1'b0, div_den_q};
        div_quo_next = {div_quo_q[30:0], !div_diff[32]};

        if (div_busy_q) begin
            div_quo_d = div_quo_next;
            div_rem_d = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
            div_cnt_d = div_cnt_q + 5'd1;
            if (div_cnt_q == 5'd31) begin
                div_busy_d = 1'b0;
                acc_d      = div_neg_q ? -div_quo_next : div_quo_next;
            end
        end

        case (p_state_q)
            P_OPCODE: begin
                if (!rx_empty) begin
                    rx_pop    = 1'b1;
                    opcode_d  = rx_head;
                    p_state_d = P_RSVD;
                end
            end
            P_RSVD: begin
                if (!rx_empty) begin
                    rx_pop    = 1'b1;
                    p_state_d = P_LEN_LO;
                end
            end
            P_LEN_LO: begin
                if (!rx_empty) begin
                    rx_pop    = 1'b1;
                    len_lo_d  = rx_head;
                    p_state_d = P_LEN_HI;
                end
            end
            P_LEN_HI: begin
                if (!rx_empty) begin
                    rx_pop     = 1'b1;
                    remain_d   = (pkt_len < 16'd4) ? 16'd0 : pkt_len - 16'd4;
                    byte_idx_d = '0;
                    first_d    = 1'b1;
                    acc_d      = (opcode_q == OP_MUL) ? 32'd1 : 32'd0;
                    p_state_d  = (pkt_len <= 16'd4) ? P_EXEC : P_PAYLOAD;
                end
            end
            P_PAYLOAD: begin
                if (payload_ok) begin
                    rx_pop     = 1'b1;
                    remain_d   = remain_q - 16'd1;
                    operand_d  = full_word;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (remain_q == 16'd1) begin
                        p_state_d = P_EXEC;
                    end
                    if (opcode_q == OP_ECHO) begin
                        tx_push = 1'b1;
                        tx_data = rx_head;
                    end
                    if (byte_idx_q == 2'd3) begin
                        if (opcode_q == OP_ADD) begin
                            acc_d = acc_q + full_word;
                        end else if (opcode_q == OP_MUL) begin
                            acc_d = acc_q * full_word;
                        end else if (opcode_q == OP_DIV) begin
                            first_d = 1'b0;
                            if (first_q) begin
                                acc_d = full_word;
                            end else if (full_word == 32'd0) begin
                                acc_d = 32'hFFFF_FFFF;
                            end else begin
                                div_busy_d = 1'b1;
                                div_cnt_d  = '0;
                                div_rem_d  = '0;
                                div_quo_d  = acc_q[31] ? -acc_q : acc_q;
                                div_den_d  = full_word[31] ? -full_word : full_word;
                                div_neg_d  = acc_q[31] ^ full_word[31];
                            end
                        end
                    end
                end
            end
            P_EXEC: begin
                if (!div_busy_q) begin
                    resp_idx_d = '0;
                    p_state_d  = is_arith ? P_RESPOND : P_OPCODE;
                end
            end
            P_RESPOND: begin
                if (!tx_full) begin
                    tx_push    = 1'b1;
                    tx_data    = acc_q[{resp_idx_q, 3'b000} +: 8];
                    resp_idx_d = resp_idx_q + 2'd1;
                    if (resp_idx_q == 2'd3) begin
                        p_state_d = P_OPCODE;
                    end
                end
            end
            default: p_state_d = P_OPCODE;
        endcase
    end

    // Parser and datapath registers; reset abandons any packet in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_state_q  <= P_OPCODE;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            remain_q   <= '0;
            operand_q  <= '0;
            byte_idx_q <= '0;
            first_q    <= 1'b1;
            acc_q      <= '0;
            resp_idx_q <= '0;
            div_busy_q <= 1'b0;
            div_cnt_q  <= '0;
            div_rem_q  <= '0;
            div_quo_q  <= '0;
            div_den_q  <= '0;
            div_neg_q  <= 1'b0;
        end else begin
            p_state_q  <= p_state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            remain_q   <= remain_d;
            operand_q  <= operand_d;
            byte_idx_q <= byte_idx_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
            resp_idx_q <= resp_idx_d;
            div_busy_q <= div_busy_d;
            div_cnt_q  <= div_cnt_d;
            div_rem_q  <= div_rem_d;
            div_quo_q  <= div_quo_d;
            div_den_q  <= div_den_d;
            div_neg_q  <= div_neg_d;
        end
    end

    uart_alu_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(8)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_push),
        .data_i  (tx_data),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .empty_o (tx_empty),
        .full_o  (tx_full)
    );

    // Transmitter: next byte is taken at the end of the stop bit so queued bytes leave with no idle gap.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Transmitter registers; the line output is registered to stay glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_alu.sv
// Testbench for uart_alu: drives serial packets, decodes the serial reply and
// compares it against a plain-arithmetic reference model.

module tb_uart_alu;
    localparam int PRESCALE = 1;
    localparam int BIT_CYC  = 8 * PRESCALE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  rxQ[$];
    logic [7:0]  byteQ[$];
    logic [31:0] opsQ[$];

    uart_alu #(.PRESCALE(PRESCALE), .DATA_WIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rx_i  (rx),
        .tx_o  (tx)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: result of an arithmetic packet over the operands in opsQ.
    function automatic logic [31:0] refModel(input logic [7:0] op);
        logic [31:0] acc;
        int signed a;
        int signed b;
        acc = 32'd0;
        if (op == 8'h01) begin
            foreach (opsQ[i]) acc = acc + opsQ[i];
        end else if (op == 8'h02) begin
            acc = 32'd1;
            foreach (opsQ[i]) acc = acc * opsQ[i];
        end else if (op == 8'h03 && opsQ.size() > 0) begin
            a = opsQ[0];
            for (int i = 1; i < opsQ.size(); i++) begin
                b = opsQ[i];
                if (b == 0) a = -1;
                else if (!(a == 32'sh8000_0000 && b == -1)) a = a / b;
            end
            acc = a;
        end
        return acc;
    endfunction

    // Serial decoder for the DUT output; pushes each received byte into rxQ.
    initial begin : txMonitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (BIT_CYC / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT_CYC) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (BIT_CYC) @(negedge clk);
                    checkOutput("tx_stop_bit", {31'd0, tx}, 32'd1);
                    rxQ.push_back(b);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (95000) @(negedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendByte(input logic [7:0] b);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        while (byteQ.size() > 0) sendByte(byteQ.pop_front());
    endtask

    // Packet with header, opsQ operands little-endian, then 'extra' trailing bytes.
    task automatic buildArith(input logic [7:0] op, input int extra);
        int len;
        len = 4 + 4 * opsQ.size() + extra;
        byteQ.push_back(op);
        byteQ.push_back(8'h00);
        byteQ.push_back(8'(len));
        byteQ.push_back(8'(len >> 8));
        foreach (opsQ[i]) for (int k = 0; k < 4; k++) byteQ.push_back(opsQ[i][8*k +: 8]);
        repeat (extra) byteQ.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic expectWord(input string tag, input logic [31:0] exp, input bit quiet);
        int c;
        logic [31:0] w;
        c = 0;
        while (rxQ.size() < 4 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        if (rxQ.size() < 4) begin
            checkOutput({tag, " resp_bytes"}, rxQ.size(), 32'd4);
        end else begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = rxQ.pop_front();
            checkOutput(tag, w, exp);
        end
        if (quiet) begin
            repeat (3 * BIT_CYC * 10) @(negedge clk);
            checkOutput({tag, " extra_bytes"}, rxQ.size(), 32'd0);
            rxQ.delete();
        end
    endtask

    task automatic runArith(input logic [7:0] op, input string tag, input int extra, input logic [31:0] exp);
        buildArith(op, extra);
        applyStimulus();
        expectWord(tag, exp, 1'b1);
    endtask

    task automatic randomOps(input int n, input bit smallDivisors);
        int s;
        opsQ.delete();
        for (int i = 0; i < n; i++) begin
            if (smallDivisors && i > 0 && $urandom_range(0, 2) != 0) begin
                s = $urandom_range(0, 20);
                opsQ.push_back(32'(s - 10));
            end else begin
                opsQ.push_back($urandom);
            end
        end
    endtask

    initial begin : main
        logic [31:0] e1;
        logic [31:0] e2;
        logic [7:0]  echoBytes[8];

        rst = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (50) @(negedge clk);
            checkOutput("idle_tx", {31'd0, tx}, 32'd1);
        end
        checkOutput("idle_no_bytes", rxQ.size(), 32'd0);

        opsQ = '{32'd5, 32'd7};
        runArith(8'h01, "add_basic", 0, 32'h0000_000C);
        opsQ = '{32'hFFFF_FFFF, 32'd2};
        runArith(8'h01, "add_overflow", 0, 32'h0000_0001);
        opsQ = '{32'd100, 32'd23};
        runArith(8'h01, "add_trailing_partial", 3, 32'd123);
        opsQ.delete();
        runArith(8'h01, "add_zero_ops", 0, 32'd0);
        runArith(8'h02, "mul_zero_ops", 0, 32'd1);
        runArith(8'h03, "div_zero_ops", 0, 32'd0);
        byteQ = '{8'h02, 8'h00, 8'h02, 8'h00};
        applyStimulus();
        expectWord("mul_short_len", 32'd1, 1'b1);
        for (int t = 0; t < 3; t++) begin
            randomOps($urandom_range(2, 5), 1'b0);
            runArith(8'h01, "add_random", 0, refModel(8'h01));
        end

        opsQ = '{32'h0001_0000, 32'h0001_0000, 32'd5};
        runArith(8'h02, "mul_wrap", 0, 32'h0000_0000);
        opsQ = '{32'hFFFF_FFFD, 32'd7};
        runArith(8'h02, "mul_neg", 0, 32'hFFFF_FFEB);
        for (int t = 0; t < 3; t++) begin
            randomOps($urandom_range(2, 5), 1'b0);
            runArith(8'h02, "mul_random", 0, refModel(8'h02));
        end

        opsQ = '{32'hFFFF_FFF9, 32'd2};
        runArith(8'h03, "div_neg_dividend", 0, 32'hFFFF_FFFD);
        opsQ = '{32'd100, 32'hFFFF_FFF9};
        runArith(8'h03, "div_neg_divisor", 0, 32'hFFFF_FFF2);
        opsQ = '{32'd1234, 32'd0};
        runArith(8'h03, "div_by_zero", 0, 32'hFFFF_FFFF);
        opsQ = '{32'h8000_0000, 32'hFFFF_FFFF};
        runArith(8'h03, "div_overflow", 0, 32'h8000_0000);
        for (int t = 0; t < 4; t++) begin
            randomOps($urandom_range(2, 3), 1'b1);
            runArith(8'h03, "div_random", 0, refModel(8'h03));
        end

        byteQ = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        applyStimulus();
        expectWord("echo_fixed", 32'h1234_5678, 1'b1);
        byteQ = '{8'hEC, 8'h00, 8'h0C, 8'h00};
        for (int i = 0; i < 8; i++) begin
            echoBytes[i] = 8'($urandom_range(0, 255));
            byteQ.push_back(echoBytes[i]);
        end
        applyStimulus();
        expectWord("echo_random_lo", {echoBytes[3], echoBytes[2], echoBytes[1], echoBytes[0]}, 1'b0);
        expectWord("echo_random_hi", {echoBytes[7], echoBytes[6], echoBytes[5], echoBytes[4]}, 1'b1);

        byteQ = '{8'h55, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        applyStimulus();
        repeat (400) @(negedge clk);
        checkOutput("unknown_no_resp", rxQ.size(), 32'd0);
        opsQ = '{32'd40, 32'd2};
        runArith(8'h01, "add_after_unknown", 0, 32'd42);

        opsQ = '{32'd1, 32'd2, 32'd3};
        buildArith(8'h01, 0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) sendByte(byteQ.pop_front());
        byteQ.delete();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_mid_payload_tx", {31'd0, tx}, 32'd1);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        checkOutput("rst_no_resp", rxQ.size(), 32'd0);
        checkOutput("rst_idle_tx", {31'd0, tx}, 32'd1);
        randomOps(2, 1'b0);
        runArith(8'h01, "add_after_reset", 0, refModel(8'h01));

        randomOps(2, 1'b0);
        e1 = refModel(8'h01);
        buildArith(8'h01, 0);
        randomOps(3, 1'b0);
        e2 = refModel(8'h02);
        buildArith(8'h02, 0);
        applyStimulus();
        expectWord("b2b_first", e1, 1'b0);
        expectWord("b2b_second", e2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
